// File: rtl/gb_mem_pkg.sv
// Shared memory-map constants and DMA state type for the
// Game Boy OAM DMA slice.
package gb_mem_pkg;

  localparam int OAM_LEN   = 160;
  localparam int GB_ADDR_W = 15;

  typedef enum logic {
    IDLE,
    RUN
  } dma_state_t;

  function automatic logic [15:0] page_addr(
    input logic [7:0] page,
    input logic [7:0] idx
  );
    return {page, idx};
  endfunction

endpackage

// File: rtl/gb_oam_dma_if.sv
// Bus bundle of the OAM DMA: CPU request side, bram read
// port and OAM write port. master = the DMA engine.
interface gb_oam_dma_if #(
  parameter int ADDR_W = 15
) ();

  logic              start;
  logic [7:0]        src_page;
  logic              busy;
  logic              done;
  logic              src_en;
  logic              src_we;
  logic [ADDR_W-1:0] src_addr;
  logic [7:0]        src_dout;
  logic              dst_en;
  logic              dst_we;
  logic [7:0]        dst_addr;
  logic [7:0]        dst_din;

  modport master (
    input  start,
    input  src_page,
    input  src_dout,
    output busy,
    output done,
    output src_en,
    output src_we,
    output src_addr,
    output dst_en,
    output dst_we,
    output dst_addr,
    output dst_din
  );

  modport slave (
    output start,
    output src_page,
    output src_dout,
    input  busy,
    input  done,
    input  src_en,
    input  src_we,
    input  src_addr,
    input  dst_en,
    input  dst_we,
    input  dst_addr,
    input  dst_din
  );

endinterface

// File: rtl/gb_oam_dma_timer.sv
// Per-byte phase counter of the OAM DMA: issue, capture
// and last-phase strobes derived from the phase value.
module dma_step_timer #(
  parameter int STEP_CYCLES  = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic clka,
  input  logic rsta,
  input  logic clear,
  input  logic en,
  output logic issue,
  output logic capture,
  output logic last_phase
);

  localparam int PW =
    (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  localparam logic [PW-1:0] CAP_PH  = PW'(READ_LATENCY);
  localparam logic [PW-1:0] LAST_PH = PW'(STEP_CYCLES - 1);
  localparam logic [PW-1:0] ONE     = PW'(1);

  logic [PW-1:0] phase;

  always_ff @(posedge clka) begin
    if (rsta || clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= last_phase ? '0 : phase + ONE;
    end
  end

  assign issue      = (phase == '0);
  assign capture    = (phase == CAP_PH);
  assign last_phase = (phase == LAST_PH);

endmodule

// File: rtl/gb_oam_dma.sv
// OAM DMA engine: copies LEN bytes of a bram page into OAM.
// GB_OAM_DMA_RESTART_EN: start during RUN restarts the copy.
module gb_oam_dma
  import gb_mem_pkg::*;
#(
  parameter int LEN          = OAM_LEN,
  parameter int STEP_CYCLES  = 4,
  parameter int READ_LATENCY = 1,
  parameter int ADDR_W       = GB_ADDR_W
) (
  input logic          clka,
  input logic          rsta,
  gb_oam_dma_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(LEN - 1);

  dma_state_t state, state_n;
  logic [7:0] idx, idx_n;
  logic [7:0] page, page_n;

  logic clr;
  logic run;
  logic restart;
  logic issue;
  logic capture;
  logic last_phase;

  logic [15:0] full_addr;
  logic        src_en;
  logic        dst_en;
  logic        done;

  dma_step_timer #(
    .STEP_CYCLES (STEP_CYCLES),
    .READ_LATENCY(READ_LATENCY)
  ) u_timer (
    .clka      (clka),
    .rsta      (rsta),
    .clear     (clr),
    .en        (run),
    .issue     (issue),
    .capture   (capture),
    .last_phase(last_phase)
  );

  always_ff @(posedge clka) begin
    if (rsta) begin
      state <= IDLE;
      idx   <= '0;
      page  <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      page  <= page_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    page_n  = page;
    clr     = 1'b0;
    run     = 1'b0;
    restart = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        clr = 1'b1;
        if (bus.start) begin
          page_n  = bus.src_page;
          idx_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        run = 1'b1;
`ifdef GB_OAM_DMA_RESTART_EN
        restart = bus.start;
`else
        restart = 1'b0;
`endif
        // a restart abandons the current copy, so no done pulse
        if (restart) begin
          page_n = bus.src_page;
          idx_n  = '0;
          clr    = 1'b1;
        end else if (last_phase) begin
          if (idx == LAST_IDX) begin
            done    = 1'b1;
            idx_n   = '0;
            state_n = IDLE;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign full_addr = page_addr(page, idx);
  assign src_en    = run && issue;
  assign dst_en    = run && capture;

  assign bus.busy     = run;
  assign bus.done     = done;
  assign bus.src_en   = src_en;
  assign bus.src_we   = 1'b0;
  assign bus.src_addr = run ? full_addr[ADDR_W-1:0] : '0;
  assign bus.dst_en   = dst_en;
  assign bus.dst_we   = dst_en;
  assign bus.dst_addr = dst_en ? idx : 8'h00;
  assign bus.dst_din  = dst_en ? bus.src_dout : 8'h00;

endmodule

// File: tb/tb_gb_oam_dma.sv
// Directed bench for gb_oam_dma: three instances with read
// latency 0, 1 and 2 share one request stream.
module tb_gb_oam_dma;
  import gb_mem_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] page = 8'h00;

  always #5 clk = ~clk;

  gb_oam_dma_if #(.ADDR_W(15)) b0 ();
  gb_oam_dma_if #(.ADDR_W(15)) b1 ();
  gb_oam_dma_if #(.ADDR_W(15)) b2 ();

  assign b0.start    = start;
  assign b1.start    = start;
  assign b2.start    = start;
  assign b0.src_page = page;
  assign b1.src_page = page;
  assign b2.src_page = page;

  gb_oam_dma #(.READ_LATENCY(0)) u0 (
    .clka(clk), .rsta(rst), .bus(b0.master));
  gb_oam_dma #(.READ_LATENCY(1)) u1 (
    .clka(clk), .rsta(rst), .bus(b1.master));
  gb_oam_dma #(.READ_LATENCY(2)) u2 (
    .clka(clk), .rsta(rst), .bus(b2.master));

  function automatic logic [7:0] memf(input logic [14:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] d2a;
  assign b0.src_dout = memf(b0.src_addr);
  always @(posedge clk) begin
    if (b1.src_en) b1.src_dout <= memf(b1.src_addr);
    if (b2.src_en) d2a <= memf(b2.src_addr);
    b2.src_dout <= d2a;
  end

  int cyc = 0;
  int nchk = 0;
  int nfail = 0;
  int t0, ta, t1;
  logic [7:0] oam [3][256];
  int wr_n [3];
  int done_n [3];
  int done_cyc [3];
  int first_we [3];
  int lat_err [3];
  int last_en [3];
  logic [14:0] rd_q [$];

  task automatic mon(input int i, input logic en,
                     input logic de, input logic we,
                     input logic dn, input logic [7:0] da,
                     input logic [7:0] dd);
    if (en) last_en[i] = cyc;
    if (de !== we) lat_err[i]++;
    if (we) begin
      if (first_we[i] < 0) first_we[i] = cyc;
      if (cyc - last_en[i] != i) lat_err[i]++;
      oam[i][da] = dd;
      wr_n[i]++;
    end
    if (dn) begin
      done_n[i]++;
      done_cyc[i] = cyc;
    end
  endtask

  always @(posedge clk) begin
    mon(0, b0.src_en, b0.dst_en, b0.dst_we, b0.done,
        b0.dst_addr, b0.dst_din);
    mon(1, b1.src_en, b1.dst_en, b1.dst_we, b1.done,
        b1.dst_addr, b1.dst_din);
    mon(2, b2.src_en, b2.dst_en, b2.dst_we, b2.done,
        b2.dst_addr, b2.dst_din);
    if (b1.src_en) rd_q.push_back(b1.src_addr);
    cyc++;
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic til(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic go(input logic [7:0] p);
    start = 1'b1;
    page  = p;
    t0    = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic clr_stats();
    for (int i = 0; i < 3; i++) begin
      wr_n[i]     = 0;
      done_n[i]   = 0;
      done_cyc[i] = -1;
      first_we[i] = -1;
      lat_err[i]  = 0;
      last_en[i]  = -100;
      for (int k = 0; k < 256; k++) oam[i][k] = 8'hEE;
    end
    rd_q.delete();
  endtask

  function automatic int bad_pat(input int i, input int lo,
                                 input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (oam[i][k] !== (8'(k) ^ 8'h5A)) n++;
    return n;
  endfunction

  function automatic int bad_fill(input int i, input int lo,
                                  input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++)
      if (oam[i][k] !== 8'hEE) n++;
    return n;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_ctl"},
        {58'd0, b1.busy, b1.done, b1.src_en, b1.src_we,
         b1.dst_en, b1.dst_we}, 64'd0);
    chk({tag, "_bus"},
        {33'd0, b1.src_addr, b1.dst_addr, b1.dst_din}, 64'd0);
  endtask

  initial begin
    clr_stats();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    chk("reset_busy0", b0.busy, 0);

    // reset and start together: reset wins
    rst = 1'b1; start = 1'b1; page = 8'h12;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk_idle("rst_start");

    // basic copy of page 0x12
    clr_stats();
    go(8'h12);
    til(t0 + 1);
    chk("bas_busy1", b1.busy, 1);
    chk("bas_src0", {b1.src_en, b1.src_addr}, {1'b1, 15'h1200});
    til(t0 + 640);
    chk("bas_done", {b1.busy, b1.done}, 2'b11);
    til(t0 + 641);
    chk("bas_fall", {b1.busy, b1.done}, 2'b00);
    chk("bas_nrd", rd_q.size(), 160);
    chk("bas_rd0", rd_q[0], 15'h1200);
    chk("bas_rdl", rd_q[159], 15'h129F);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("bas_wr%0d", i), wr_n[i], 160);
      chk($sformatf("bas_lat%0d", i), lat_err[i], 0);
      chk($sformatf("bas_we1st%0d", i), first_we[i], t0 + 1 + i);
      chk($sformatf("bas_oam%0d", i), bad_pat(i, 0, 159), 0);
      chk($sformatf("bas_dcyc%0d", i), done_cyc[i], t0 + 640);
    end

    // page 0xFF wraps into the 15-bit address space
    clr_stats();
    go(8'hFF);
    til(t0 + 645);
    chk("wrap_rd0", rd_q[0], 15'h7F00);
    chk("wrap_rdl", rd_q[$], 15'h7F9F);
    chk("wrap_oam", bad_pat(1, 0, 159), 0);

    // back-to-back on the first non-busy cycle
    clr_stats();
    go(8'h40);
    t1 = t0 + 641;
    til(t1);
    chk("b2b_idle", b1.busy, 0);
    go(8'h30);
    til(t1 + 1);
    chk("b2b_src0", {b1.src_en, b1.src_addr}, {1'b1, 15'h3000});
    til(t1 + 645);
    chk("b2b_dn", done_n[1], 2);
    chk("b2b_dcyc", done_cyc[1], t1 + 640);
    chk("b2b_nrd", rd_q.size(), 320);
    chk("b2b_rd159", rd_q[159], 15'h409F);
    chk("b2b_rd160", rd_q[160], 15'h3000);
    chk("b2b_rd319", rd_q[319], 15'h309F);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2b_wr%0d", i), wr_n[i], 320);
      chk($sformatf("b2b_lat%0d", i), lat_err[i], 0);
      chk($sformatf("b2b_oam%0d", i), bad_pat(i, 0, 159), 0);
    end

    // start arrives during byte 49's final phase
    clr_stats();
    go(8'h12);
    ta = t0;
    til(ta + 200);
    go(8'h20);
    til(ta + 201);
`ifdef GB_OAM_DMA_RESTART_EN
    chk("rs_next", b1.src_addr, 15'h2000);
    til(ta + 845);
    chk("rs_rd50", rd_q[50], 15'h2000);
    chk("rs_dn", done_n[1], 1);
    chk("rs_dcyc", done_cyc[1], ta + 840);
    chk("rs_wr", wr_n[1], 210);
`else
    chk("rs_next", b1.src_addr, 15'h1232);
    til(ta + 845);
    chk("rs_rd50", rd_q[50], 15'h1232);
    chk("rs_dn", done_n[1], 1);
    chk("rs_dcyc", done_cyc[1], ta + 640);
    chk("rs_wr", wr_n[1], 160);
`endif
    chk("rs_oam", bad_pat(1, 0, 159), 0);

    // reset during byte 80's read cycle
    clr_stats();
    go(8'h12);
    ta = t0;
    til(ta + 321);
    chk("rm_src80", {b1.src_en, b1.src_addr}, {1'b1, 15'h1250});
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rm_idle");
    repeat (700) @(negedge clk);
    chk("rm_wr1", wr_n[1], 80);
    chk("rm_wr2", wr_n[2], 80);
    chk("rm_wr0", wr_n[0], 81);
    chk("rm_dn", done_n[1], 0);
    chk("rm_oam_lo", bad_pat(1, 0, 79), 0);
    chk("rm_oam_hi", bad_fill(1, 80, 159), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule

// File: doc/gb_oam_dma.md
# gb_oam_dma

OAM DMA engine: the initiator that drives a bram port as a read-only client and copies one page of it into OAM. On a start request it reads `LEN` consecutive bytes from source address `{src_page, 8'h00}` and writes each into OAM index 0..`LEN`-1, one byte per `STEP_CYCLES` clocks. The engine sits between the CPU register decode (0xFF46 write produces `start`/`src_page`) and the bram/OAM memories.

## Interface
- `LEN`, 160, bytes per transfer (1..256)
- `STEP_CYCLES`, 4, clocks per byte (≥1)
- `READ_LATENCY`, 1, clocks from `src_en` to valid `src_dout` (0..`STEP_CYCLES`-1)
- `ADDR_W`, 15, source address width
- `clka`  in  1  clock
- `rsta`  in  1  reset, synchronous, active-high
- `start`  in  1  one-cycle transfer request
- `src_page`  in  8  source page (high address byte), sampled with `start`
- `busy`  out  1  transfer in progress (CPU bus lockout)
- `done`  out  1  one-cycle pulse on final byte write
- `src_en`  out  1  source read enable (bram `ena`)
- `src_we`  out  1  tied 0 (bram `wea`)
- `src_addr`  out  `ADDR_W`  source byte address
- `src_dout`  in  8  source read data
- `dst_en`, `dst_we`  out  1  OAM write strobe (both asserted together)
- `dst_addr`  out  8  OAM index
- `dst_din`  out  8  OAM write data

## Operation
- States: IDLE, RUN.
- IDLE: `start`=1 latches `src_page`, clears `idx` and `phase`, and enters RUN.
- RUN, per byte: `phase` counts 0..`STEP_CYCLES`-1.
  - `phase`=0: `src_en`=1, `src_addr`=`{src_page, idx}` truncated to `ADDR_W` bits. Page 0xFF with `ADDR_W`=15 wraps to 0x7F00.
  - `phase`=`READ_LATENCY`: `dst_en`=`dst_we`=1, `dst_addr`=`idx`, `dst_din`=`src_dout` (combinational pass-through, no extra register).
  - `phase`=`STEP_CYCLES`-1: `idx` increments and `phase` returns to 0.
  - Last byte (`idx`=`LEN`-1, final phase): `done`=1 and the next state is IDLE.
- `busy`=1 exactly while in RUN.
- `src_en` and `dst_en` are 0 at every other phase and in IDLE.
- `idx` is 8 bits; `LEN`=256 is legal, with the terminal test on `idx`=255.
- `start` while in RUN: see Configuration.
- `rsta` (any state): the next cycle is IDLE with all outputs 0 (`src_addr`, `dst_addr`, `dst_din` driven 0). No further strobes; a partial OAM copy is left as is.
- `rsta` and `start` in the same cycle: reset wins.

## Timing
- `start` at cycle T. `busy`=1 from T+1. First `src_en` at T+1. First `dst_we` at T+1+`READ_LATENCY`.
- Byte k: read at T+1+k·`STEP_CYCLES`.
- `done` at T+`LEN`·`STEP_CYCLES`. `busy` falls at T+`LEN`·`STEP_CYCLES`+1.
- Default: 640 busy cycles.
- A `start` in the same cycle `done` is asserted is treated as a RUN-state request (Configuration).
- A `start` on the first cycle `busy` is low begins a new transfer.

## Configuration
- `GB_OAM_DMA_RESTART_EN` defined:
  - `start` in RUN relatches `src_page` and resets `idx`=0, `phase`=0 the next cycle.
  - `done` is not pulsed for the aborted transfer.
  - Matches hardware restart behaviour.
- Undefined: `start` in RUN is ignored and the transfer completes unchanged.

## Structure
- Shared package `gb_mem_pkg`:
  - `OAM_LEN`=160, `GB_ADDR_W`=15
  - state enum `dma_state_t` {IDLE, RUN}
- One sub-module, `dma_step_timer`:
  - `phase` counter with `STEP_CYCLES` wrap, synchronous clear and active-high `rsta`
  - outputs `issue` (`phase`=0), `capture` (`phase`=`READ_LATENCY`), `last_phase`
- Top level holds the FSM, `idx`, and the page register.

## Test plan
- Basic copy (defaults): `src_page`=0x12, bram preloaded with `mem[a]=a[7:0]^0x5A`.
  - Reads 0x1200..0x129F; OAM[i]=i^0x5A for i=0..159.
  - `done` at T+640; `busy` low at T+641.
- Latency sweep: `READ_LATENCY`=0, then 2 (`STEP_CYCLES`=4).
  - `dst_we` at phase 0, then 2.
  - OAM contents identical to the basic copy.
- Wrap: `src_page`=0xFF, `ADDR_W`=15.
  - First `src_addr`=0x7F00, last 0x7F9F.
- Restart at byte 50 with `src_page`=0x20:
  - With macro: next read 0x2000, OAM[0] rewritten, single `done` at restart+640.
  - Without macro: reads continue 0x1232.., `done` at original T+640.
- Reset mid-transfer at byte 80: `rsta` pulse.
  - All outputs 0 next cycle.
  - No `dst_we` after reset.
  - OAM[80..159] unchanged.
- Back-to-back: second `start` on the first non-busy cycle, page 0x30.
  - Begins immediately; no missed or duplicated OAM write.
